// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard scan-code decoder.
// Synchronises and glitch-filters the raw PS/2 lines, frames 11-bit words,
// and walks the E0/F0/E1 prefix grammar to produce a make code, a shift
// level, a one-cycle key strobe and a held flag.
`timescale 1ns/1ps
module ps2_scan_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] incode,
  output logic       shift,
  output logic       key_stb,
  output logic       key_held,
  output logic       frame_err
);

  localparam int              TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]   TO_ONE  = TW'(1);

  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] C_BRK   = 8'hF0;
  localparam logic [7:0] C_PAUSE = 8'hE1;
  localparam logic [7:0] C_LSH   = 8'h12;
  localparam logic [7:0] C_RSH   = 8'h59;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronisers and clock glitch filter
  // ---------------------------------------------------------------------
  logic [1:0]            clk_sync_q;
  logic [1:0]            dat_sync_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  clk_f_q;
  logic                  clk_f_prev_q;
  logic                  fall;

  // Two-flop synchronisers; both lines idle high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end

  // Filtered clock only moves once the whole sample window agrees
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q       <= '1;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
    end else begin
      filt_q <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
      if (&filt_q) begin
        clk_f_q <= 1'b1;
      end else if (~|filt_q) begin
        clk_f_q <= 1'b0;
      end
      clk_f_prev_q <= clk_f_q;
    end
  end

  // Data is sampled a filter-delay after the real fall; the keyboard holds
  // data stable for the whole low phase, so this lag is harmless.
  assign fall = clk_f_prev_q & ~clk_f_q;

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shreg_q;
  logic [TW-1:0] to_cnt_q;
  logic          byte_vld_q;
  logic [7:0]    byte_q;
  logic          frame_err_q;
  logic          frame_ok;

  // Start low, odd parity over data+parity, stop (the bit arriving now) high
  assign frame_ok = ~shreg_q[0] & (^shreg_q[9:1]) & dat_sync_q[1];

  // Bit counter, shift register, stall timeout and byte/error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 10'd0;
      to_cnt_q    <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        to_cnt_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= 4'd0;
          if (frame_ok) begin
            byte_vld_q <= 1'b1;
            byte_q     <= shreg_q[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          shreg_q[bit_cnt_q] <= dat_sync_q[1];
          bit_cnt_q          <= bit_cnt_q + 4'd1;
        end
      end else begin
        // Saturate so an idle bus never wraps into a false timeout
        if (to_cnt_q != TO_LAST) begin
          to_cnt_q <= to_cnt_q + TO_ONE;
        end
        if ((bit_cnt_q != 4'd0) && (to_cnt_q == TO_LAST)) begin
          bit_cnt_q   <= 4'd0;
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------
  state_t     state_q;
  logic [2:0] skip_q;
  logic       lsh_q;
  logic       rsh_q;
  logic [7:0] incode_q;
  logic       shift_q;
  logic       key_stb_q;
  logic       key_held_q;
  logic       make_go;
  logic       brk_go;
  logic       act_ext;
  logic       is_lsh;
  logic       is_rsh;
  logic       is_noise;

  // Keyboard status/ack bytes that carry no key information
  assign is_noise = (byte_q == 8'hAA) || (byte_q == 8'hFA) || (byte_q == 8'hFE) ||
                    (byte_q == 8'hEE) || (byte_q == 8'h00) || (byte_q == 8'hFF);

  // Classify the current byte as a make, a break or a prefix/ignored byte
  always_comb begin
    make_go = 1'b0;
    brk_go  = 1'b0;
    act_ext = 1'b0;
    if (byte_vld_q) begin
      case (state_q)
        S_IDLE: begin
          if ((byte_q != C_EXT) && (byte_q != C_BRK) && (byte_q != C_PAUSE) && !is_noise) begin
            make_go = 1'b1;
          end
        end
        S_EXT: begin
          // E0 12 is the fake shift some keyboards emit around nav keys
          if ((byte_q != C_BRK) && (byte_q != C_LSH)) begin
            make_go = 1'b1;
            act_ext = 1'b1;
          end
        end
        S_BRK: begin
          brk_go = 1'b1;
        end
        S_EXT_BRK: begin
          if (byte_q != C_LSH) begin
            brk_go  = 1'b1;
            act_ext = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Only the plain (non-E0) codes 12/59 are real shift keys
  assign is_lsh = ~act_ext & (byte_q == C_LSH);
  assign is_rsh = ~act_ext & (byte_q == C_RSH);

  // Prefix state machine with registered key outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      skip_q     <= 3'd0;
      lsh_q      <= 1'b0;
      rsh_q      <= 1'b0;
      incode_q   <= 8'h00;
      shift_q    <= 1'b0;
      key_stb_q  <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      key_stb_q <= 1'b0;

      if (byte_vld_q) begin
        case (state_q)
          S_IDLE: begin
            if (byte_q == C_EXT) begin
              state_q <= S_EXT;
            end else if (byte_q == C_BRK) begin
              state_q <= S_BRK;
            end else if (byte_q == C_PAUSE) begin
              // Pause is E1 followed by seven bytes that are swallowed
              state_q <= S_SKIP;
              skip_q  <= 3'd7;
            end
          end
          S_EXT: begin
            state_q <= (byte_q == C_BRK) ? S_EXT_BRK : S_IDLE;
          end
          S_BRK, S_EXT_BRK: begin
            state_q <= S_IDLE;
          end
          S_SKIP: begin
            if (skip_q == 3'd1) begin
              state_q <= S_IDLE;
            end
            skip_q <= skip_q - 3'd1;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end

      if (make_go) begin
        if (is_lsh) begin
          lsh_q   <= 1'b1;
          shift_q <= 1'b1;
        end else if (is_rsh) begin
          rsh_q   <= 1'b1;
          shift_q <= 1'b1;
        end else begin
          // E0 is stripped, so right alt/ctrl land on the same codes as left
          incode_q   <= byte_q;
          key_held_q <= 1'b1;
          key_stb_q  <= ~key_stb_q;
        end
      end

      if (brk_go) begin
        if (is_lsh) begin
          lsh_q   <= 1'b0;
          shift_q <= rsh_q;
        end else if (is_rsh) begin
          rsh_q   <= 1'b0;
          shift_q <= lsh_q;
        end else if (byte_q == incode_q) begin
          key_held_q <= 1'b0;
        end
      end
    end
  end

  assign incode    = incode_q;
  assign shift     = shift_q;
  assign key_stb   = key_stb_q;
  assign key_held  = key_held_q;
  assign frame_err = frame_err_q;

endmodule
